usart_tx: RTL and testbench
===========================

// Module: usart_tx
// PURPOSE
//  USART transmit stage: register-mapped TX path between the CPU-side register bus
//  (addr/word_i/we/word_o) and the serial pins (txd, clk_o).
//  One-byte holding buffer feeds an 8N1 shift register; a baud divider times each bit.
//  Async mode or sync-master mode (DDR_XCl=1, clk_o driven). Line side feeds the pin bus.
// PARAMETERS
//  ADDR_UBRR   8'h09  address of baud divisor register (8 bit)
//  ADDR_UCSRB  8'h0A  address of control register (bit3 TXEN)
//  ADDR_UCSRA  8'h0B  address of status register (bit6 TXC, bit5 UDRE)
//  ADDR_UDR    8'h0C  address of transmit data register
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  rst      in   1  synchronous, active-high reset
//  addr     in   8  register address
//  word_i   in   8  write data
//  we       in   1  write strobe, one write per cycle when high
//  DDR_XCl  in   1  1 = sync master (clk_o driven), 0 = async (clk_o held 0)
//  word_o   out  8  read data, combinational from addr; 8'h00 for unmapped addr
//  txd      out  1  serial data, idle high, registered
//  clk_o    out  1  sync serial clock, idle low, registered
// BEHAVIOUR
//  Reset: txd=1, clk_o=0, UBRR=0, TXEN=0, UDRE=1, TXC=0, buffer empty, FSM IDLE.
//  Reset mid-frame aborts the frame; txd=1 on the cycle after rst is sampled.
//  Registers: write UBRR/UCSRB stores word_i; read returns stored value.
//  - UDR write: word_i -> buffer, UDRE<=0; write while full overwrites (old byte lost).
//  - UDR read returns last written byte. UCSRA read = {1'b0,TXC,UDRE,5'b0}.
//  - UCSRA write with word_i[6]=1 clears TXC; other bits read-only.
//  Bit period P: async 16*(UBRR+1) clk; sync 2*(UBRR+1) clk. UBRR and DDR_XCl
//  are latched at frame start; changes mid-frame apply to the next frame.
//  FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE or START.
//  - IDLE: if TXEN & buffer full: shift<=buffer, UDRE<=1, go START; txd=0 from the
//    next cycle (load-to-start-bit latency 1 clk).
//  - START, each DATA bit, STOP: txd held exactly P cycles each; frame = 10*P cycles.
//  - End of STOP: if TXEN & buffer full -> load and START directly (no idle gap);
//    else IDLE and TXC<=1.
//  - TXEN cleared mid-frame: current frame completes; buffered byte held until
//    TXEN is set again.
//  Simultaneous events:
//  - UDR write on the load cycle: shift takes old byte, buffer takes new, UDRE stays 0.
//  - TXC set and TXC-clear write in the same cycle: set wins.
//  clk_o (sync mode, in frame): low for first P/2 of every bit, high for second P/2;
//  0 in IDLE and in async mode. txd changes only at bit boundaries.
//  Divider counts from 0 to P-1, restarts at each bit boundary; no wrap drift.
// TESTING
//  1 Reset: rst=1 2 clk -> txd=1, clk_o=0, UCSRA read=8'h20, UBRR/UCSRB read 0.
//  2 UBRR=0, TXEN=1, async, write UDR=8'hA5 -> txd 0,1,0,1,0,0,1,0,1,1 each held
//    16 clk; UDRE=1 one clk after write; TXC=1 after 160 clk; UCSRA=8'h60.
//  3 Back-to-back: write 8'h55 then 8'h0F while first in flight -> 2 frames,
//    no idle gap, TXC set only after second stop bit; write 8'h40 to UCSRA -> TXC=0.
//  4 Sync: DDR_XCl=1, UBRR=1, UDR=8'h81 -> P=4 clk, clk_o 2 low/2 high per bit,
//    40-clk frame, clk_o=0 after frame; DDR_XCl=0 -> clk_o stays 0.
//  5 Boundaries: UBRR write mid-frame -> current frame timing unchanged, next uses new;
//    TXEN=0 mid-frame -> frame completes, next buffered byte not sent until TXEN=1.
//  6 Reset at DATA bit 4 -> txd=1 next clk, UCSRA=8'h20, no further frame.

Source files
------------

// File: rtl/usart_tx.sv
// USART transmit stage: register-mapped one-byte holding buffer feeding an 8N1 shifter,
// with a per-frame latched baud divider and optional sync-master serial clock.
module usart_tx #(
   parameter logic [7:0] ADDR_UBRR  = 8'h09,
   parameter logic [7:0] ADDR_UCSRB = 8'h0A,
   parameter logic [7:0] ADDR_UCSRA = 8'h0B,
   parameter logic [7:0] ADDR_UDR   = 8'h0C
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] addr,
   input  logic [7:0] word_i,
   input  logic       we,
   input  logic       DDR_XCl,
   output logic [7:0] word_o,
   output logic       txd,
   output logic       clk_o
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state_q;
   logic [7:0]  ubrr_q, ucsrb_q, udr_q, shift_q, lat_ubrr_q;
   logic        full_q, txc_q, lat_sync_q, txd_q, clk_o_q;
   logic [2:0]  bit_cnt_q;
   logic [11:0] div_q;

   logic        wr_udr, clr_txc, bit_end, load;
   logic [12:0] period;

   always_comb begin
      wr_udr  = we && (addr == ADDR_UDR);
      clr_txc = we && (addr == ADDR_UCSRA) && word_i[6];
      // Bit period comes from the values latched at frame start, never the live register.
      period  = lat_sync_q ? (({5'b0, lat_ubrr_q} + 13'd1) << 1)
                           : (({5'b0, lat_ubrr_q} + 13'd1) << 4);
      bit_end = (state_q != IDLE) && ({1'b0, div_q} == (period - 13'd1));
      load    = ucsrb_q[3] && full_q &&
                ((state_q == IDLE) || ((state_q == STOP) && bit_end));
   end

   always_comb begin
      word_o = 8'h00;
      case (addr)
         ADDR_UBRR:  word_o = ubrr_q;
         ADDR_UCSRB: word_o = ucsrb_q;
         ADDR_UCSRA: word_o = {1'b0, txc_q, ~full_q, 5'b0};
         ADDR_UDR:   word_o = udr_q;
         default:    word_o = 8'h00;
      endcase
   end

   // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside the
   // clocked branch rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ubrr_q     <= 8'h00;
         ucsrb_q    <= 8'h00;
         udr_q      <= 8'h00;
         shift_q    <= 8'h00;
         lat_ubrr_q <= 8'h00;
         lat_sync_q <= 1'b0;
         full_q     <= 1'b0;
         txc_q      <= 1'b0;
         txd_q      <= 1'b1;
         clk_o_q    <= 1'b0;
         bit_cnt_q  <= 3'd0;
         div_q      <= 12'd0;
      end else begin
         if (we && addr == ADDR_UBRR)  ubrr_q  <= word_i;
         if (we && addr == ADDR_UCSRB) ucsrb_q <= word_i;
         if (wr_udr)                   udr_q   <= word_i;

         // A write landing on the load cycle refills the buffer, so the write wins.
         if (wr_udr)    full_q <= 1'b1;
         else if (load) full_q <= 1'b0;

         if ((state_q == STOP) && bit_end && !load) txc_q <= 1'b1;
         else if (clr_txc)                          txc_q <= 1'b0;

         if (load) begin
            state_q    <= START;
            shift_q    <= udr_q;
            lat_ubrr_q <= ubrr_q;
            lat_sync_q <= DDR_XCl;
            div_q      <= 12'd0;
            txd_q      <= 1'b0;
            clk_o_q    <= 1'b0;
         end else if (bit_end) begin
            div_q   <= 12'd0;
            clk_o_q <= 1'b0;
            case (state_q)
               START: begin
                  state_q   <= DATA;
                  txd_q     <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= 3'd0;
               end
               DATA: begin
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     txd_q     <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  txd_q   <= 1'b1;
               end
            endcase
         end else if (state_q != IDLE) begin
            div_q   <= div_q + 12'd1;
            // High for the second half of the bit: half period equals UBRR+1 in sync mode.
            clk_o_q <= lat_sync_q && (div_q >= {4'b0, lat_ubrr_q});
         end
      end
   end

   assign txd   = txd_q;
   assign clk_o = clk_o_q;

endmodule

// File: tb/tb_usart_tx.sv
// Self-checking bench for usart_tx: register vector table, directed frame scenarios and
// randomized frame streams compared cycle by cycle against a waveform model.
module tb_usart_tx;

   localparam logic [7:0] A_UBRR  = 8'h09;
   localparam logic [7:0] A_UCSRB = 8'h0A;
   localparam logic [7:0] A_UCSRA = 8'h0B;
   localparam logic [7:0] A_UDR   = 8'h0C;

   logic       clk = 1'b0;
   logic       rst, we, DDR_XCl;
   logic [7:0] addr, word_i, word_o;
   logic       txd, clk_o;

   usart_tx dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .word_i  (word_i),
      .we      (we),
      .DDR_XCl (DDR_XCl),
      .word_o  (word_o),
      .txd     (txd),
      .clk_o   (clk_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   bit exp_txd[$];
   bit exp_clk[$];

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } reg_vec_t;

   reg_vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; returns at the falling edge, which is the sample/drive point.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr = a; word_i = d; we = 1'b1;
      cyc();
      we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      addr = a; we = 1'b0;
      #1;
      d = word_o;
   endtask

   function automatic int per(input logic [7:0] u, input logic s);
      return s ? 2 * (int'(u) + 1) : 16 * (int'(u) + 1);
   endfunction

   // One 8N1 frame as a per-clock waveform: start, 8 data LSB first, stop.
   function automatic void push_frame(input logic [7:0] b, input int p, input logic s);
      bit v;
      for (int i = 0; i < 10; i++) begin
         v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
         for (int c = 0; c < p; c++) begin
            exp_txd.push_back(v);
            exp_clk.push_back(s && (c >= p / 2));
         end
      end
   endfunction

   task automatic run_stream(
      input string      tag,
      input logic [7:0] kick_addr, input logic [7:0] kick_data,
      input logic [7:0] b0, input logic [7:0] ubrr0, input logic s0,
      input int         nfr,
      input logic [7:0] b1, input logic [7:0] ubrr1, input logic s1,
      input logic       a_en, input logic [7:0] a_addr, input logic [7:0] a_data,
      input logic       b_en, input logic [7:0] b_addr, input logic [7:0] b_data,
      input logic       held
   );
      int p0, p1, total;
      logic [7:0] r, exp_st, exp_udr;
      logic e_udre, e_txd, e_clk;
      p0 = per(ubrr0, s0);
      p1 = per(ubrr1, s1);
      wr(A_UBRR, ubrr0);
      DDR_XCl = s0;
      wr(A_UCSRA, 8'h40);
      rd(A_UCSRA, r);
      check({tag, " txc_cleared"}, r[6], 1'b0);
      exp_txd.delete();
      exp_clk.delete();
      push_frame(b0, p0, s0);
      if (nfr == 2) push_frame(b1, p1, s1);
      total = exp_txd.size();

      addr = kick_addr; word_i = kick_data; we = 1'b1;
      cyc();
      we = 1'b0;
      rd(A_UCSRA, r);
      check({tag, " udre_after_write"}, r[5], 1'b0);

      for (int k = 1; k <= total + 12; k++) begin
         cyc();
         e_txd = (k - 1 < total) ? exp_txd[k-1] : 1'b1;
         e_clk = (k - 1 < total) ? exp_clk[k-1] : 1'b0;
         check($sformatf("%s txd@%0d", tag, k), txd, e_txd);
         check($sformatf("%s clk_o@%0d", tag, k), clk_o, e_clk);
         if (held)          e_udre = (k == 1);
         else if (nfr == 2) e_udre = (k == 1) || (k > 10 * p0);
         else               e_udre = 1'b1;
         exp_st = {1'b0, (k > total), e_udre, 5'b0};
         rd(A_UCSRA, r);
         check($sformatf("%s ucsra@%0d", tag, k), r, exp_st);
         if (k == 1 && a_en) begin
            addr = a_addr; word_i = a_data; we = 1'b1;
         end
         if (k == 2 && b_en) begin
            addr = b_addr; word_i = b_data; we = 1'b1;
         end
         if (k == 2 && nfr == 2) DDR_XCl = s1;
         // Clear request coinciding with the TXC set edge: the set must win.
         if (k == total) begin
            addr = A_UCSRA; word_i = 8'h40; we = 1'b1;
         end
      end
      we = 1'b0;
      exp_udr = (nfr == 2) ? b1 : ((a_en && a_addr == A_UDR) ? a_data : b0);
      rd(A_UDR, r);
      check({tag, " udr_readback"}, r, exp_udr);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] r;
      logic [7:0] b0, b1, u0, u1;
      logic s0, s1;
      int nfr, lows;

      vecs[0] = '{1'b1, A_UBRR,  8'h3C, 8'h3C};
      vecs[1] = '{1'b1, A_UCSRB, 8'hF7, 8'hF7};
      vecs[2] = '{1'b1, A_UCSRA, 8'hFF, 8'h20};
      vecs[3] = '{1'b0, 8'h00,   8'h00, 8'h00};
      vecs[4] = '{1'b0, 8'hFF,   8'h00, 8'h00};
      vecs[5] = '{1'b1, 8'h0D,   8'hAA, 8'h00};
      vecs[6] = '{1'b0, A_UBRR,  8'h00, 8'h3C};
      vecs[7] = '{1'b1, A_UBRR,  8'h00, 8'h00};
      vecs[8] = '{1'b1, A_UCSRB, 8'h08, 8'h08};
      vecs[9] = '{1'b0, A_UCSRA, 8'h00, 8'h20};

      rst = 1'b1; we = 1'b0; addr = 8'h00; word_i = 8'h00; DDR_XCl = 1'b0;
      @(negedge clk);
      cyc();
      cyc();
      check("reset txd", txd, 1'b1);
      check("reset clk_o", clk_o, 1'b0);
      rst = 1'b0;
      rd(A_UCSRA, r); check("reset ucsra", r, 8'h20);
      rd(A_UBRR, r);  check("reset ubrr", r, 8'h00);
      rd(A_UCSRB, r); check("reset ucsrb", r, 8'h00);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, r);
         check($sformatf("reg_vec%0d", i), r, vecs[i].exp);
      end
      check("no frame without data", txd, 1'b1);

      run_stream("async_a5", A_UDR, 8'hA5, 8'hA5, 8'h00, 1'b0, 1, 8'h00, 8'h00, 1'b0,
                 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      run_stream("b2b_55_0f", A_UDR, 8'h55, 8'h55, 8'h00, 1'b0, 2, 8'h0F, 8'h00, 1'b0,
                 1'b1, A_UDR, 8'h0F, 1'b1, A_UBRR, 8'h00, 1'b0);
      run_stream("sync_81", A_UDR, 8'h81, 8'h81, 8'h01, 1'b1, 1, 8'h00, 8'h01, 1'b1,
                 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      check("clk_o idle after sync", clk_o, 1'b0);
      run_stream("ubrr_midframe", A_UDR, 8'h33, 8'h33, 8'h00, 1'b0, 2, 8'hCC, 8'h02, 1'b0,
                 1'b1, A_UDR, 8'hCC, 1'b1, A_UBRR, 8'h02, 1'b0);
      run_stream("txen_off", A_UDR, 8'h3C, 8'h3C, 8'h00, 1'b0, 1, 8'h00, 8'h00, 1'b0,
                 1'b1, A_UDR, 8'hC3, 1'b1, A_UCSRB, 8'h00, 1'b1);
      run_stream("txen_resume", A_UCSRB, 8'h08, 8'hC3, 8'h00, 1'b0, 1, 8'h00, 8'h00, 1'b0,
                 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

      for (int it = 0; it < 8; it++) begin
         b0  = 8'($urandom);
         b1  = 8'($urandom);
         u0  = 8'($urandom_range(0, 2));
         u1  = 8'($urandom_range(0, 2));
         s0  = 1'($urandom_range(0, 1));
         s1  = 1'($urandom_range(0, 1));
         nfr = int'($urandom_range(1, 2));
         run_stream($sformatf("rand%0d", it), A_UDR, b0, b0, u0, s0, nfr, b1, u1, s1,
                    nfr == 2, A_UDR, b1, nfr == 2, A_UBRR, u1, 1'b0);
      end

      wr(A_UBRR, 8'h00);
      DDR_XCl = 1'b0;
      wr(A_UCSRA, 8'h40);
      addr = A_UDR; word_i = 8'hA5; we = 1'b1;
      cyc();
      we = 1'b0;
      for (int k = 1; k <= 5 * 16 + 3; k++) cyc();
      check("data bit4 before reset", txd, 1'b0);
      rst = 1'b1;
      cyc();
      check("midframe reset txd", txd, 1'b1);
      check("midframe reset clk_o", clk_o, 1'b0);
      rd(A_UCSRA, r); check("midframe reset ucsra", r, 8'h20);
      rd(A_UBRR, r);  check("midframe reset ubrr", r, 8'h00);
      rd(A_UCSRB, r); check("midframe reset ucsrb", r, 8'h00);
      rst = 1'b0;
      lows = 0;
      for (int k = 0; k < 300; k++) begin
         cyc();
         if (txd !== 1'b1) lows++;
      end
      check("no frame after reset", lows, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
